booth_r4_multiplier: RTL and testbench
======================================

Name: booth_r4_multiplier

Overview:
- Parametrised radix-4 (modified Booth) sequential multiplier. It is the next generation of the 8-bit radix-2 Booth multiplier.
- Adds generic operand width, a per-operation signed/unsigned mode, a one-cycle done pulse, asynchronous reset, and roughly half the iteration count.
- Sits on the datapath as a multi-cycle arithmetic unit, driven by a start/busy handshake.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and ≥ 4; checked by elaboration-time assertion.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned. Latched with operands.
- a  input  WIDTH  multiplicand; latched when start is accepted.
- b  input  WIDTH  multiplier; latched when start is accepted.
- product  output  2*WIDTH  result; holds the last completed result.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when product is updated.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, product=0, busy=0, done=0, all internal registers 0. Reset mid-operation aborts the operation; no done pulse is produced for it.
- Constant ITER = WIDTH/2 + 1 (5 for WIDTH=8).
- States:
  - IDLE: on a clk edge with start=1 and busy=0, the operation is accepted.
  - RUN: iteration counter runs from 0 to ITER-1.
- Acceptance edge:
  - Latch M = a extended to WIDTH+2 bits (sign-extended if signed_mode, else zero-extended).
  - Multiplier register Q = b extended to WIDTH+2 bits the same way, with an appended LSB q(-1)=0.
  - Accumulator P (2*WIDTH+4 bits) cleared; count=0; busy←1; state←RUN.
- Each RUN edge:
  - Encode Q[2:0] (including q(-1)) into a digit d ∈ {0, +1, +2, −1, −2}.
  - P ← P + d·M·2^(2·count), sign-extended to the full accumulator width. This is equivalent to a shift-add form: add to the upper part, then arithmetic-shift P and Q right by 2.
  - Q shifts right by 2; count increments.
- Completion edge (count = ITER-1): product ← low 2*WIDTH bits of the final sum; done←1 for exactly this one cycle; busy←0; state←IDLE.
- Latency: done is high in the cycle following the ITER-th edge after the acceptance edge. busy is high for exactly ITER cycles. Worst case equals best case; there is no early termination.
- start while busy=1 is ignored. Operands and mode changes during RUN have no effect.
- start=1 in the done cycle (busy=0) is accepted at that edge. Back-to-back throughput is therefore one result per ITER+1 cycles.
- product is stable from done until the next completion edge. It is not cleared on acceptance.
- Arithmetic rules:
  - Signed: result is the exact two's-complement 2*WIDTH product, including −2^(W−1) × −2^(W−1) = +2^(2W−2).
  - Unsigned: exact; the extra extension bits guarantee the top digit never goes negative.
- Holding start high continuously restarts a new operation each time busy falls.

Decomposition:
- Shared package (booth_pkg):
  - State encoding constants IDLE/RUN.
  - Booth digit select encoding: ZERO, POS1, POS2, NEG1, NEG2.
  - Helper function ITER(WIDTH).
- Sub-module booth_r4_encoder: combinational. Input is 3 multiplier bits; outputs are neg, two, zero selects. This is the single natural split.
- Accumulator, counter and FSM stay in the top module.

Test Plan:
- WIDTH=8, unsigned, a=3, b=17, start pulsed one cycle:
  - busy high for 5 cycles.
  - done pulses once; product=51 (0x0033).
  - product holds 51 afterward.
- WIDTH=8, unsigned, a=255, b=255 → product=65025 (0xFE01). Then a=7, b=7 issued in the done cycle → accepted immediately; product=49 after another 5 busy cycles.
- WIDTH=8, signed:
  - a=−3 (0xFD), b=17 → product=0xFFCD (−51).
  - a=0x80, b=0x80 → product=0x4000 (+16384).
  - a=0x80, b=0x7F → product=0xC080 (−16256).
- start re-asserted, and a/b/signed_mode changed, mid-RUN → ignored. busy length unchanged; result is that of the original operands; exactly one done.
- rst asserted asynchronously (between clk edges) mid-RUN → busy, done and product go to 0 immediately; no done after release; a subsequent start works normally.
- WIDTH=16: random signed and unsigned pairs plus corner cases 0, 1, max, min → product matches the reference model. busy is 9 cycles per operation.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM states, digit
// encoding and the iteration-count helper.
package booth_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // Two extension bits plus the appended q(-1) need one digit more than WIDTH/2.
  function automatic int booth_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Modified-Booth recoder: three overlapping multiplier bits {q(i+1), q(i), q(i-1)}
// become a digit in {0, +1, +2, -1, -2}, presented as neg/two/zero selects.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] bits,
  output logic       neg,
  output logic       two,
  output logic       zero
);

  booth_digit_e digit;

  always_comb begin
    digit = ZERO;
    case (bits)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
    neg  = (digit == NEG1) || (digit == NEG2);
    two  = (digit == POS2) || (digit == NEG2);
    zero = (digit == ZERO);
  end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, WIDTH-bit operands, signed or unsigned
// per operation, WIDTH/2+1 iterations per product.
module booth_r4_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output state_e               dbg_state
);

  localparam int XW = WIDTH + 2;
  localparam int PW = 2 * WIDTH + 4;
  localparam int N  = booth_iter(WIDTH);
  localparam int CW = $clog2(N);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("booth_r4_multiplier: WIDTH must be even and >= 4");
  end

  // Handshake: start is accepted on a rising edge only while busy=0 (state IDLE);
  // busy then stays high for exactly N cycles, and done pulses for one cycle in
  // the cycle product is updated. That done cycle is idle and may accept start.

  state_e                state_q, state_d;
  logic [XW-1:0]         m_q, m_d;
  logic [XW:0]           q_q, q_d;
  logic [PW-1:0]         p_q, p_d;
  logic [CW-1:0]         count_q, count_d;
  logic [2*WIDTH-1:0]    product_q, product_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  sel_neg, sel_two, sel_zero;
  logic [PW-1:0]         m_ext, mag, addend, shifted, p_sum;
  logic [CW:0]           shamt;

  booth_r4_encoder u_encoder (
    .bits (q_q[2:0]),
    .neg  (sel_neg),
    .two  (sel_two),
    .zero (sel_zero)
  );

  // Partial product d*M placed at weight 4^count, sign-extended to the accumulator.
  always_comb begin
    m_ext   = {{(PW-XW){m_q[XW-1]}}, m_q};
    mag     = sel_two ? (m_ext << 1) : m_ext;
    addend  = sel_zero ? '0 : (sel_neg ? (~mag + 1'b1) : mag);
    shamt   = {count_q, 1'b0};
    shifted = addend << shamt;
    p_sum   = p_q + shifted;
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    p_d       = p_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {{2{signed_mode & a[WIDTH-1]}}, a};
          q_d     = {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
          p_d     = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d     = p_sum;
        q_d     = {{2{q_q[XW]}}, q_q[XW:2]};
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          product_d = p_sum[2*WIDTH-1:0];
          done_d    = 1'b1;
          busy_d    = 1'b0;
          count_d   = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      p_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      p_q       <= p_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product   = product_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Self-checking bench for booth_r4_multiplier at WIDTH=8 and WIDTH=16 against
// a plain-arithmetic product model.
module tb_booth_r4_multiplier;
  import booth_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] product8;
  logic        busy8, done8;
  state_e      st8;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] product16;
  logic        busy16, done16;
  state_e      st16;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  booth_r4_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .product(product8), .busy(busy8), .done(done8), .dbg_state(st8)
  );

  booth_r4_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
    .product(product16), .busy(busy16), .done(done16), .dbg_state(st16)
  );

  always #5 clk = ~clk;

  // Exact product of two w-bit operands, truncated to 2w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic s);
    longint sx, sy, r;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[w-1]) sx = sx - (longint'(1) << w);
    if (s && y[w-1]) sy = sy - (longint'(1) << w);
    r = sx * sy;
    return 32'(r & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Launch one 8-bit op; optionally disturb inputs mid-run. Reports busy cycles,
  // done pulses and the product captured in the done cycle.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic s,
                     input logic disturb, output int busy_cyc, output int done_cnt,
                     output logic [15:0] prod);
    @(negedge clk);
    a8 = ia; b8 = ib; sm8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_cyc = 0; done_cnt = 0; prod = '0;
    for (int i = 0; i < 10; i++) begin
      if (disturb && i == 1) begin
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~s;
      end
      if (disturb && i == 3) start8 = 1'b0;
      if (busy8) busy_cyc++;
      if (done8) begin done_cnt++; prod = product8; end
      @(negedge clk);
    end
  endtask

  task automatic op16(input logic [15:0] ia, input logic [15:0] ib, input logic s,
                      output int busy_cyc, output int done_cnt, output logic [31:0] prod);
    @(negedge clk);
    a16 = ia; b16 = ib; sm16 = s; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    busy_cyc = 0; done_cnt = 0; prod = '0;
    for (int i = 0; i < 14; i++) begin
      if (busy16) busy_cyc++;
      if (done16) begin done_cnt++; prod = product16; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (product8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0 || st8 !== IDLE) begin
      failures++;
      $display("FAIL reset8: product=%h busy=%b done=%b state=%0d, want 0/0/0/IDLE",
               product8, busy8, done8, st8);
    end
    checks++;
    if (product16 !== 32'h0 || busy16 !== 1'b0 || done16 !== 1'b0 || st16 !== IDLE) begin
      failures++;
      $display("FAIL reset16: product=%h busy=%b done=%b, want 0/0/0", product16, busy16, done16);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int bc, dc;
    logic [15:0] p;
    op8(8'd3, 8'd17, 1'b0, 1'b0, bc, dc, p);
    checks++;
    if (bc !== 5 || dc !== 1) begin
      failures++;
      $display("FAIL basic_timing: busy=%0d done=%0d, want 5/1", bc, dc);
    end
    checks++;
    if (p !== 16'd51) begin
      failures++;
      $display("FAIL basic_product: got %h want %h", p, 16'd51);
    end
    checks++;
    if (product8 !== 16'd51) begin
      failures++;
      $display("FAIL basic_hold: got %h want %h", product8, 16'd51);
    end
  endtask

  task automatic test_signed8;
    int bc, dc;
    logic [15:0] p;
    logic [7:0] ta[3] = '{8'hFD, 8'h80, 8'h80};
    logic [7:0] tb_[3] = '{8'd17, 8'h80, 8'h7F};
    logic [15:0] want[3] = '{16'hFFCD, 16'h4000, 16'hC080};
    for (int i = 0; i < 3; i++) begin
      op8(ta[i], tb_[i], 1'b1, 1'b0, bc, dc, p);
      checks++;
      if (p !== want[i] || p !== 16'(ref_mul(8, {8'h0, ta[i]}, {8'h0, tb_[i]}, 1'b1)) || dc !== 1) begin
        failures++;
        $display("FAIL signed8[%0d]: got %h done=%0d want %h", i, p, dc, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int k, bc, dc;
    logic [15:0] p;
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd255; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    while (done8 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (done8 !== 1'b1 || product8 !== 16'hFE01) begin
      failures++;
      $display("FAIL b2b_first: done=%b product=%h want 1/%h", done8, product8, 16'hFE01);
    end
    a8 = 8'd7; b8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b want 1", busy8);
    end
    bc = 0; dc = 0; p = '0;
    for (int i = 0; i < 10; i++) begin
      if (busy8) bc++;
      if (done8) begin dc++; p = product8; end
      @(negedge clk);
    end
    checks++;
    if (p !== 16'd49 || bc !== 5 || dc !== 1) begin
      failures++;
      $display("FAIL b2b_second: product=%h busy=%0d done=%0d want 0031/5/1", p, bc, dc);
    end
  endtask

  task automatic test_midrun_ignore;
    int bc, dc;
    logic [15:0] p;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x, y;
      logic s;
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_mul(8, {8'h0, x}, {8'h0, y}, s));
      op8(x, y, s, 1'b1, bc, dc, p);
      checks++;
      if ({16'h0, p} !== exp_q.pop_front() || bc !== 5 || dc !== 1) begin
        failures++;
        $display("FAIL midrun[%0d]: a=%h b=%h s=%b got %h busy=%0d done=%0d", i, x, y, s, p, bc, dc);
      end
    end
  endtask

  task automatic test_async_reset;
    int dc, bc;
    logic [15:0] p;
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd200; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'h0) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b product=%h want 0/0/0", busy8, done8, product8);
    end
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      if (done8 || busy8) dc++;
      @(negedge clk);
    end
    checks++;
    if (dc !== 0 || product8 !== 16'h0) begin
      failures++;
      $display("FAIL async_no_done: activity=%0d product=%h want 0/0", dc, product8);
    end
    op8(8'd12, 8'd13, 1'b0, 1'b0, bc, dc, p);
    checks++;
    if (p !== 16'd156 || bc !== 5 || dc !== 1) begin
      failures++;
      $display("FAIL async_recover: product=%h busy=%0d done=%0d want 009c/5/1", p, bc, dc);
    end
  endtask

  task automatic test_random16;
    int bc, dc;
    logic [31:0] p;
    logic [15:0] corners[4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000};
    for (int i = 0; i < 40; i++) begin
      logic [15:0] x, y;
      logic s;
      x = (i < 16) ? corners[i % 4] : 16'($urandom);
      y = (i < 16) ? corners[i / 4] : 16'($urandom);
      s = (i < 16) ? 1'(i % 2) : 1'($urandom_range(0, 1));
      exp_q.push_back(ref_mul(16, x, y, s));
      op16(x, y, s, bc, dc, p);
      checks++;
      if (p !== exp_q.pop_front() || bc !== 9 || dc !== 1) begin
        failures++;
        $display("FAIL random16[%0d]: a=%h b=%h s=%b got %h busy=%0d done=%0d want %h",
                 i, x, y, s, p, bc, dc, ref_mul(16, x, y, s));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed8();
    test_back_to_back();
    test_midrun_ignore();
    test_async_reset();
    test_random16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
